temporal_buffer_reader: RTL and testbench
=========================================

// Module: temporal_buffer_reader
// PURPOSE
// - Read-side sequencer for the per-flip temporal buffer array: on start, drives the selected flip index
//   to the buffer read port and captures the MCPV x (NSAT-1) literal bus into a shadow register.
// - Streams the non-empty clause slots one clause per beat over valid/ready to the clause-update stage.
// - Lets the buffer array be rewritten for the next flip round while the previous selection drains.
// PARAMETERS
// - NSAT  3   literals per clause; a clause slot holds NSAT-1 literals (self literal excluded)
// - LAW   11  literal address width; literal = {polarity[LAW], address[LAW-1:0]}, LAW+1 bits
// - MCPV  20  max clauses per variable = number of clause slots
// PORTS
// - clk              in   1                    clock, all state on rising edge
// - reset            in   1                    asynchronous, active-low reset
// - start_i          in   1                    begin read of sel_index_i; sampled only in IDLE
// - sel_index_i      in   $clog2(NSAT)         flip chosen by heuristic selector
// - busy_o           out  1                    high in any state other than IDLE
// - read_index_o     out  $clog2(NSAT)         to buffer array read_index
// - literals_multi_i in   (NSAT-1)*MCPV*(LAW+1) from buffer array; slot k at [k*(NSAT-1)*(LAW+1) +: (NSAT-1)*(LAW+1)]
// - clause_o         out  (NSAT-1)*(LAW+1)      current clause literals
// - clause_idx_o     out  $clog2(MCPV)         slot index of clause_o
// - valid_o          out  1                    clause_o/clause_idx_o/last_o valid
// - ready_i          in   1                    downstream accepts; beat transfers when valid_o & ready_i
// - last_o           out  1                    current beat is the final non-empty slot
// - done_o           out  1                    one-cycle pulse, read round finished
// BEHAVIOUR
// - Reset (reset==0, any state, mid-stream included): FSM->IDLE, shadow/mask/ptr/read_index_o cleared;
//   valid_o=0, busy_o=0, done_o=0, last_o=0, clause_o=0, clause_idx_o=0. No beat in flight survives.
// - Empty slot: all NSAT-1 literal addresses == 0 (polarity ignored). Nonempty mask nz[k] per slot.
// - FSM states IDLE, FETCH, STREAM, DONE:
//   IDLE:   start_i=1 -> read_index_o<=sel_index_i, ->FETCH. start_i ignored in every other state.
//   FETCH:  exactly 1 cycle (covers a registered buffer read). At its end: shadow<=literals_multi_i,
//           mask<=nz; if nz==0 -> DONE, else ptr<=lowest set index of nz, ->STREAM.
//   STREAM: valid_o=1; clause_o=shadow slot ptr; clause_idx_o=ptr.
//           last_o = no mask bit set above ptr. On handshake: clear mask[ptr];
//           if last_o -> DONE, else ptr<=next set index above ptr (no bubble: back-to-back beats with
//           ready_i held high). ready_i low -> all outputs held stable, valid_o stays high.
//   DONE:   done_o=1 for this cycle only, ->IDLE. busy_o low the cycle after.
// - Latency: start_i accepted at edge t -> first valid_o at t+2. N non-empty slots, ready_i=1 ->
//   N beats in consecutive cycles, done_o the cycle after the last handshake.
// - read_index_o holds its value after FETCH until the next start; literals_multi_i is not sampled
//   outside FETCH, so buffer writes during STREAM do not affect the stream.
// - Index order strictly ascending; each non-empty slot emitted exactly once; empty slots never emitted.
// - sel_index_i >= NSAT: not checked here; the selector guarantees range.
// - Widths: ptr $clog2(MCPV) bits; next-index search never exceeds MCPV-1.
// STRUCTURE
// - Shared header sat_defs.vh: literal field positions (polarity bit LAW, address [LAW-1:0]),
//   CLAUSE_W=(NSAT-1)*(LAW+1), FSM state encodings, slot-empty function.
// - One sub-module: next_set_index #(.W(MCPV)) -- combinational; inputs mask, start position;
//   outputs found and lowest set index >= start. Used for first slot (start 0) and advance (ptr+1);
//   last_o = ~found for start ptr+1.
// - Remainder (FSM, shadow register, slot mux) in temporal_buffer_reader.
// TESTING (NSAT=3, LAW=11, MCPV=20, CLAUSE_W=24)
// - Slots 0,5,19 non-empty, ready=1, start sel=2 -> read_index_o=2; beats idx 0,5,19 on cycles t+2..t+4,
//   last_o only on idx 19, done_o at t+5.
// - All slots zero (polarity bits set, addresses 0) -> no valid_o, done_o at t+2, busy_o low at t+3.
// - Slots 3,4 non-empty, ready low for 3 cycles on idx 3 -> clause_o/idx/last held; idx 4 follows handshake.
// - Buffer bus changed to all-ones during STREAM -> emitted clauses still match bus sampled in FETCH.
// - start_i pulsed while busy -> ignored; read_index_o unchanged, stream unaffected.
// - reset asserted mid-STREAM at idx 5 -> valid_o, busy_o, done_o drop immediately; after release,
//   new start streams the fresh selection from its lowest slot.

Source files
------------

// File: rtl/temporal_buffer_reader_pkg.sv
// Shared definitions for the temporal buffer read sequencer.
//   - tbr_state_e : read FSM state encoding
//   - clause_width: bits in one clause slot (NSAT-1 literals, self literal excluded)
// A literal is {polarity[LAW], address[LAW-1:0]}; a slot is empty when every
// literal address in it is zero, whatever the polarity bits hold.
package temporal_buffer_reader_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFetch  = 2'd1,
        StStream = 2'd2,
        StDone   = 2'd3
    } tbr_state_e;

    function automatic int unsigned clause_width(int unsigned nsat, int unsigned law);
        return (nsat - 1) * (law + 1);
    endfunction

endpackage

// File: rtl/temporal_buffer_reader_next_set_index.sv
// Combinational lowest-set-bit search at or above a start position.
//   mask_i  : candidate bits
//   start_i : first position considered; one bit wider than an index so that
//             "one past the last slot" is representable and yields found_o=0
//   found_o : some mask bit at or above start_i is set
//   index_o : lowest such position (0 when found_o=0)
module temporal_buffer_reader_next_set_index #(
    parameter int unsigned W = 20
) (
    input  logic [W-1:0]         mask_i,
    input  logic [$clog2(W):0]   start_i,
    output logic                 found_o,
    output logic [$clog2(W)-1:0] index_o
);

    localparam int unsigned IW = $clog2(W);

    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (!found_o && mask_i[i] && ((IW + 1)'(i) >= start_i)) begin
                found_o = 1'b1;
                index_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/temporal_buffer_reader.sv
// Read-side sequencer for the per-flip temporal buffer array.
// On start it points the buffer read port at the selected flip, snapshots the
// whole clause-slot bus one cycle later, then streams the non-empty slots in
// ascending order, one clause per valid/ready beat. The buffer may be
// rewritten for the next round while the snapshot drains.
//   clk, reset         : clock, asynchronous active-low reset
//   start_i/sel_index_i: begin a read of the given flip (only honoured in idle)
//   busy_o             : sequencer not idle
//   read_index_o       : buffer array read index
//   literals_multi_i   : all MCPV clause slots from the buffer array
//   clause_o/clause_idx_o/last_o/valid_o/ready_i : clause stream
//   done_o             : one-cycle pulse at the end of a read round
module temporal_buffer_reader
    import temporal_buffer_reader_pkg::*;
#(
    parameter int unsigned NSAT = 3,
    parameter int unsigned LAW  = 11,
    parameter int unsigned MCPV = 20,
    localparam int unsigned IW  = $clog2(NSAT),
    localparam int unsigned PW  = $clog2(MCPV),
    localparam int unsigned CW  = clause_width(NSAT, LAW)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [IW-1:0]    sel_index_i,
    output logic             busy_o,
    output logic [IW-1:0]    read_index_o,
    input  logic [MCPV*CW-1:0] literals_multi_i,
    output logic [CW-1:0]    clause_o,
    output logic [PW-1:0]    clause_idx_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             last_o,
    output logic             done_o
);

    tbr_state_e               state_q, state_d;
    logic [IW-1:0]            read_index_q, read_index_d;
    logic [MCPV-1:0][CW-1:0]  shadow_q, shadow_d;
    logic [MCPV-1:0]          mask_q, mask_d;
    logic [PW-1:0]            ptr_q, ptr_d;

    logic [MCPV-1:0]          nz;
    logic                     first_found;
    logic [PW-1:0]            first_idx;
    logic                     next_found;
    logic [PW-1:0]            next_idx;
    logic [PW:0]              next_start;

    // Non-empty slot mask straight off the bus; only consumed during FETCH.
    always_comb begin
        nz = '0;
        for (int unsigned k = 0; k < MCPV; k++) begin
            for (int unsigned j = 0; j < NSAT - 1; j++) begin
                if (literals_multi_i[k*CW + j*(LAW+1) +: LAW] != '0) begin
                    nz[k] = 1'b1;
                end
            end
        end
    end

    assign next_start = (PW + 1)'(ptr_q) + (PW + 1)'(1);

    temporal_buffer_reader_next_set_index #(
        .W (MCPV)
    ) u_first (
        .mask_i  (nz),
        .start_i ('0),
        .found_o (first_found),
        .index_o (first_idx)
    );

    // No set bit above ptr means the current beat is the final one.
    temporal_buffer_reader_next_set_index #(
        .W (MCPV)
    ) u_next (
        .mask_i  (mask_q),
        .start_i (next_start),
        .found_o (next_found),
        .index_o (next_idx)
    );

    always_comb begin
        state_d      = state_q;
        read_index_d = read_index_q;
        shadow_d     = shadow_q;
        mask_d       = mask_q;
        ptr_d        = ptr_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    read_index_d = sel_index_i;
                    state_d      = StFetch;
                end
            end
            StFetch: begin
                shadow_d = literals_multi_i;
                mask_d   = nz;
                if (first_found) begin
                    ptr_d   = first_idx;
                    state_d = StStream;
                end else begin
                    state_d = StDone;
                end
            end
            StStream: begin
                if (ready_i) begin
                    mask_d[ptr_q] = 1'b0;
                    if (next_found) begin
                        ptr_d = next_idx;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            read_index_q <= '0;
            shadow_q     <= '0;
            mask_q       <= '0;
            ptr_q        <= '0;
        end else begin
            state_q      <= state_d;
            read_index_q <= read_index_d;
            shadow_q     <= shadow_d;
            mask_q       <= mask_d;
            ptr_q        <= ptr_d;
        end
    end

    always_comb begin
        valid_o      = (state_q == StStream);
        busy_o       = (state_q != StIdle);
        done_o       = (state_q == StDone);
        read_index_o = read_index_q;
        clause_o     = valid_o ? shadow_q[ptr_q] : '0;
        clause_idx_o = valid_o ? ptr_q : '0;
        last_o       = valid_o & ~next_found;
    end

endmodule

// File: tb/tb_temporal_buffer_reader.sv
// Directed bench for temporal_buffer_reader (NSAT=3, LAW=11, MCPV=20).
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_temporal_buffer_reader;

    localparam int unsigned NSAT = 3;
    localparam int unsigned LAW  = 11;
    localparam int unsigned MCPV = 20;
    localparam int unsigned CW   = 24;

    logic                     clk;
    logic                     reset;
    logic                     start_i;
    logic [1:0]               sel_index_i;
    logic                     busy_o;
    logic [1:0]               read_index_o;
    logic [MCPV-1:0][CW-1:0]  bus;
    logic [CW-1:0]            clause_o;
    logic [4:0]               clause_idx_o;
    logic                     valid_o;
    logic                     ready_i;
    logic                     last_o;
    logic                     done_o;

    int checks = 0;
    int errors = 0;

    temporal_buffer_reader #(
        .NSAT (NSAT),
        .LAW  (LAW),
        .MCPV (MCPV)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start_i          (start_i),
        .sel_index_i      (sel_index_i),
        .busy_o           (busy_o),
        .read_index_o     (read_index_o),
        .literals_multi_i (bus),
        .clause_o         (clause_o),
        .clause_idx_o     (clause_idx_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .last_o           (last_o),
        .done_o           (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] mk(input logic p1, input logic [10:0] a1,
                                         input logic p0, input logic [10:0] a0);
        return {p1, a1, p0, a0};
    endfunction

    task automatic expect_beat(input string tag, input logic [4:0] idx,
                               input logic [CW-1:0] cl, input logic last);
        check({tag, ".valid"}, 32'(valid_o), 32'd1);
        check({tag, ".idx"}, 32'(clause_idx_o), 32'(idx));
        check({tag, ".clause"}, 32'(clause_o), 32'(cl));
        check({tag, ".last"}, 32'(last_o), 32'(last));
        check({tag, ".done"}, 32'(done_o), 32'd0);
    endtask

    // Present start for exactly one edge; returns just after the accepting edge.
    task automatic start_round(input logic [1:0] sel);
        start_i     = 1'b1;
        sel_index_i = sel;
        step();
        start_i     = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] c0, c1, c2;
        start_i     = 1'b0;
        sel_index_i = '0;
        ready_i     = 1'b1;
        bus         = '0;
        reset       = 1'b0;
        #12;
        check("rst.busy", 32'(busy_o), 32'd0);
        check("rst.valid", 32'(valid_o), 32'd0);
        check("rst.done", 32'(done_o), 32'd0);
        check("rst.rdidx", 32'(read_index_o), 32'd0);
        reset = 1'b1;
        step();

        // Slots 0,5,19: ascending, back-to-back beats.
        c0 = mk(1'b0, 11'd7, 1'b1, 11'd0);
        c1 = mk(1'b1, 11'd0, 1'b0, 11'd300);
        c2 = mk(1'b1, 11'h7ff, 1'b1, 11'h400);
        bus = '0;
        bus[0] = c0; bus[5] = c1; bus[19] = c2;
        bus[3] = mk(1'b1, 11'd0, 1'b1, 11'd0);   // polarity only: still empty
        start_round(2'd2);
        check("t1.fetch.busy", 32'(busy_o), 32'd1);
        check("t1.fetch.valid", 32'(valid_o), 32'd0);
        check("t1.rdidx", 32'(read_index_o), 32'd2);
        step();
        expect_beat("t1.b0", 5'd0, c0, 1'b0);
        step();
        expect_beat("t1.b5", 5'd5, c1, 1'b0);
        step();
        expect_beat("t1.b19", 5'd19, c2, 1'b1);
        step();
        check("t1.done", 32'(done_o), 32'd1);
        check("t1.done.valid", 32'(valid_o), 32'd0);
        check("t1.done.busy", 32'(busy_o), 32'd1);
        step();
        check("t1.idle.busy", 32'(busy_o), 32'd0);
        check("t1.idle.done", 32'(done_o), 32'd0);
        check("t1.idle.rdidx", 32'(read_index_o), 32'd2);

        // All addresses zero, polarity bits set: no beats.
        for (int k = 0; k < int'(MCPV); k++) bus[k] = mk(1'b1, 11'd0, 1'b1, 11'd0);
        start_round(2'd1);
        check("t2.fetch.valid", 32'(valid_o), 32'd0);
        step();
        check("t2.done", 32'(done_o), 32'd1);
        check("t2.valid", 32'(valid_o), 32'd0);
        step();
        check("t2.busy", 32'(busy_o), 32'd0);
        check("t2.done.off", 32'(done_o), 32'd0);

        // Slots 3,4 with back-pressure on slot 3.
        c0 = mk(1'b0, 11'd1, 1'b0, 11'd2);
        c1 = mk(1'b1, 11'd3, 1'b0, 11'd0);
        bus = '0;
        bus[3] = c0; bus[4] = c1;
        start_round(2'd0);
        ready_i = 1'b0;
        step();
        expect_beat("t3.b3", 5'd3, c0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_beat("t3.hold", 5'd3, c0, 1'b0);
        end
        ready_i = 1'b1;
        step();
        expect_beat("t3.b4", 5'd4, c1, 1'b1);
        step();
        check("t3.done", 32'(done_o), 32'd1);
        step();

        // Bus overwritten after FETCH; stray start while busy.
        c0 = mk(1'b0, 11'd10, 1'b0, 11'd11);
        c1 = mk(1'b1, 11'd12, 1'b1, 11'd13);
        c2 = mk(1'b0, 11'd0, 1'b1, 11'd14);
        bus = '0;
        bus[1] = c0; bus[2] = c1; bus[7] = c2;
        start_round(2'd1);
        step();
        bus = '1;
        start_i = 1'b1;
        sel_index_i = 2'd2;
        expect_beat("t4.b1", 5'd1, c0, 1'b0);
        step();
        start_i = 1'b0;
        expect_beat("t4.b2", 5'd2, c1, 1'b0);
        check("t4.rdidx", 32'(read_index_o), 32'd1);
        step();
        expect_beat("t4.b7", 5'd7, c2, 1'b1);
        step();
        check("t4.done", 32'(done_o), 32'd1);
        step();
        check("t4.idle", 32'(busy_o), 32'd0);
        check("t4.rdidx.hold", 32'(read_index_o), 32'd1);

        // Reset mid-stream, then a fresh round.
        c0 = mk(1'b0, 11'd7, 1'b1, 11'd0);
        c1 = mk(1'b1, 11'd0, 1'b0, 11'd300);
        bus = '0;
        bus[0] = c0; bus[5] = c1; bus[19] = mk(1'b0, 11'd1, 1'b0, 11'd1);
        start_round(2'd2);
        step();
        step();
        expect_beat("t5.b5", 5'd5, c1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("t5.rst.valid", 32'(valid_o), 32'd0);
        check("t5.rst.busy", 32'(busy_o), 32'd0);
        check("t5.rst.done", 32'(done_o), 32'd0);
        check("t5.rst.last", 32'(last_o), 32'd0);
        check("t5.rst.clause", 32'(clause_o), 32'd0);
        check("t5.rst.idx", 32'(clause_idx_o), 32'd0);
        check("t5.rst.rdidx", 32'(read_index_o), 32'd0);
        #1;
        reset = 1'b1;
        c0 = mk(1'b0, 11'd20, 1'b0, 11'd21);
        c1 = mk(1'b1, 11'd22, 1'b0, 11'd0);
        bus = '0;
        bus[2] = c0; bus[9] = c1;
        step();
        check("t5.post.busy", 32'(busy_o), 32'd0);
        start_round(2'd1);
        check("t5.rdidx", 32'(read_index_o), 32'd1);
        step();
        expect_beat("t5.n2", 5'd2, c0, 1'b0);
        step();
        expect_beat("t5.n9", 5'd9, c1, 1'b1);
        step();
        check("t5.done", 32'(done_o), 32'd1);
        step();
        check("t5.idle", 32'(busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
